// File: rtl/ps2_mouse_rx.sv
// Receive-only PS/2 mouse front end.
// Synchronises the raw PS/2 pins, deserialises 11-bit device-to-host frames,
// assembles 3-byte movement packets and integrates the signed deltas into an
// absolute cursor position clamped to the visible area.
module ps2_mouse_rx #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int X_INIT      = 320,
  parameter int Y_INIT      = 240,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] mouse_position_x,
  output logic [15:0] mouse_position_y,
  output logic        btn_left,
  output logic        btn_right,
  output logic        btn_middle,
  output logic        packet_valid,
  output logic        frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic signed [16:0] X_MAX = 17'(H_RES - 1);
  localparam logic signed [16:0] Y_MAX = 17'(V_RES - 1);

  typedef enum logic [1:0] {
    B0  = 2'd0,
    B1  = 2'd1,
    B2  = 2'd2,
    UPD = 2'd3
  } pkt_state_t;

  // Input conditioning
  logic [1:0]  clk_sync_r;
  logic [1:0]  data_sync_r;
  logic        clk_prev_r;
  logic        fall_s;

  // Frame deserialiser
  logic [3:0]  bit_cnt_r;
  logic [9:0]  shift_r;
  logic [10:0] frame_s;
  logic        frame_ok_s;
  logic        last_bit_s;
  logic        byte_valid_r;
  logic [7:0]  byte_r;
  logic        frame_err_r;

  // Timeout
  logic [TW-1:0] to_cnt_r;
  logic          to_active_s;
  logic          timeout_s;

  // Packet assembly
  pkt_state_t  state_r;
  pkt_state_t  state_s;
  logic        ld_status_s;
  logic        ld_dx_s;
  logic        upd_s;
  logic [7:0]  status_r;
  logic [7:0]  dx_r;

  // Position arithmetic
  logic signed [16:0] dx_s;
  logic signed [16:0] dy_s;
  logic signed [16:0] nx_s;
  logic signed [16:0] ny_s;
  logic [15:0]        x_clamp_s;
  logic [15:0]        y_clamp_s;

  // Output registers
  logic [15:0] x_r;
  logic [15:0] y_r;
  logic [2:0]  btn_r;
  logic        packet_valid_r;

  // Falling edge of the synchronised PS/2 clock; data is taken in this cycle.
  assign fall_s     = clk_prev_r & ~clk_sync_r[1];
  assign last_bit_s = (bit_cnt_r == 4'd10);
  // frame_s[0] is the start bit, [8:1] data, [9] parity, [10] stop.
  assign frame_s    = {data_sync_r[1], shift_r};
  assign frame_ok_s = ~frame_s[0] & frame_s[10] & (^frame_s[9:1]);

  assign to_active_s = (bit_cnt_r != 4'd0) || (state_r != B0);
  // A falling edge in the same cycle always wins over the timeout.
  assign timeout_s   = ~fall_s & to_active_s & (to_cnt_r == TO_LAST);

  // Two-flop synchronisers; idle-high reset values avoid a spurious edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
      clk_prev_r  <= 1'b1;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2_clk};
      data_sync_r <= {data_sync_r[0], ps2_data};
      clk_prev_r  <= clk_sync_r[1];
    end
  end

  // Bit counter and shift register, advanced only on PS/2 falling edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_r <= 4'd0;
      shift_r   <= 10'd0;
    end else if (fall_s) begin
      shift_r   <= {data_sync_r[1], shift_r[9:1]};
      bit_cnt_r <= last_bit_s ? 4'd0 : bit_cnt_r + 4'd1;
    end else if (timeout_s) begin
      bit_cnt_r <= 4'd0;
    end else begin
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // Frame check at the stop bit: hand over a good byte, flag a bad frame or timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_valid_r <= 1'b0;
      byte_r       <= 8'd0;
      frame_err_r  <= 1'b0;
    end else begin
      byte_valid_r <= fall_s & last_bit_s & frame_ok_s;
      byte_r       <= frame_s[8:1];
      frame_err_r  <= (fall_s & last_bit_s & ~frame_ok_s) | timeout_s;
    end
  end

  // Inactivity counter: runs mid-frame or mid-packet, cleared by every edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_r <= '0;
    end else if (fall_s || !to_active_s || timeout_s) begin
      to_cnt_r <= '0;
    end else begin
      to_cnt_r <= to_cnt_r + 1'b1;
    end
  end

  // Packet FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= B0;
    end else begin
      state_r <= state_s;
    end
  end

  // Packet FSM next state; bad frames and timeouts drop back to byte 0.
  always_comb begin
    state_s     = state_r;
    ld_status_s = 1'b0;
    ld_dx_s     = 1'b0;
    upd_s       = 1'b0;
    if (timeout_s || frame_err_r) begin
      state_s = B0;
    end else begin
      case (state_r)
        B0: begin
          // Bit 3 is always set in a status byte; anything else is a resync drop.
          if (byte_valid_r && byte_r[3]) begin
            ld_status_s = 1'b1;
            state_s     = B1;
          end else begin
            state_s = B0;
          end
        end
        B1: begin
          if (byte_valid_r) begin
            ld_dx_s = 1'b1;
            state_s = B2;
          end else begin
            state_s = B1;
          end
        end
        B2: begin
          // The dy byte is consumed directly so outputs change on entering UPD.
          if (byte_valid_r) begin
            upd_s   = 1'b1;
            state_s = UPD;
          end else begin
            state_s = B2;
          end
        end
        UPD:     state_s = B0;
        default: state_s = B0;
      endcase
    end
  end

  // Status and dx byte latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_r <= 8'd0;
      dx_r     <= 8'd0;
    end else begin
      if (ld_status_s) begin
        status_r <= byte_r;
      end else begin
        status_r <= status_r;
      end
      if (ld_dx_s) begin
        dx_r <= byte_r;
      end else begin
        dx_r <= dx_r;
      end
    end
  end

  // Signed 9-bit deltas, overflow suppression and clamped new position.
  always_comb begin
    dx_s      = 17'sd0;
    dy_s      = 17'sd0;
    x_clamp_s = x_r;
    y_clamp_s = y_r;
    if (status_r[6]) begin
      dx_s = 17'sd0;
    end else begin
      dx_s = {{8{status_r[4]}}, status_r[4], dx_r};
    end
    if (status_r[7]) begin
      dy_s = 17'sd0;
    end else begin
      dy_s = {{8{status_r[5]}}, status_r[5], byte_r};
    end
    nx_s = $signed({1'b0, x_r}) + dx_s;
    // PS/2 +y is up while screen +y is down.
    ny_s = $signed({1'b0, y_r}) - dy_s;
    if (nx_s < 17'sd0) begin
      x_clamp_s = 16'd0;
    end else if (nx_s > X_MAX) begin
      x_clamp_s = X_MAX[15:0];
    end else begin
      x_clamp_s = nx_s[15:0];
    end
    if (ny_s < 17'sd0) begin
      y_clamp_s = 16'd0;
    end else if (ny_s > Y_MAX) begin
      y_clamp_s = Y_MAX[15:0];
    end else begin
      y_clamp_s = ny_s[15:0];
    end
  end

  // Registered position, buttons and update pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_r            <= 16'(X_INIT);
      y_r            <= 16'(Y_INIT);
      btn_r          <= 3'b000;
      packet_valid_r <= 1'b0;
    end else if (upd_s) begin
      x_r            <= x_clamp_s;
      y_r            <= y_clamp_s;
      btn_r          <= {status_r[2], status_r[1], status_r[0]};
      packet_valid_r <= 1'b1;
    end else begin
      packet_valid_r <= 1'b0;
    end
  end

  assign mouse_position_x = x_r;
  assign mouse_position_y = y_r;
  assign btn_left         = btn_r[0];
  assign btn_right        = btn_r[1];
  assign btn_middle       = btn_r[2];
  assign packet_valid     = packet_valid_r;
  assign frame_err        = frame_err_r;

endmodule
